// File: rtl/fir_pkg.sv
// Shared types and default sizing for the fir host-side loader.
package fir_pkg;

  localparam int FIR_TAPS = 16;
  localparam int FIR_DW   = 16;

  typedef enum logic [2:0] {
    IDLE,
    WIND,
    LOAD,
    RUN,
    DRAIN
  } fir_state_e;

endpackage

// File: rtl/fir_loader_if.sv
// Upstream word stream, fir control/data lines and result stream of the loader.
interface fir_loader_if #(
  parameter int DW = 16
);

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  logic          fir_wind;
  logic          fir_load;
  logic          fir_in_valid;
  logic [DW-1:0] fir_data;
  logic          fir_out_valid;
  logic [DW-1:0] fir_out;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  // slave: the loader itself; master: whatever surrounds it
  modport slave (
    input  s_valid, s_data, fir_out_valid, fir_out, m_ready,
    output s_ready, fir_wind, fir_load, fir_in_valid, fir_data, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, fir_out_valid, fir_out, m_ready,
    input  s_ready, fir_wind, fir_load, fir_in_valid, fir_data, m_valid, m_data
  );

endinterface

// File: rtl/fir_loader_res_fifo.sv
// Result FIFO between fir outputs and the downstream stream.
// Pointers carry one extra bit so full and empty stay distinguishable.
module res_fifo #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          push,
  input  logic [DW-1:0]                 push_data,
  input  logic                          pop,
  output logic [DW-1:0]                 pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic          wr_en;
  logic          rd_en;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    wr_en    = push && !full;
    rd_en    = pop && !empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fir_loader.sv
// Sequences coefficient/sample loading into fir, issues credit-limited
// in_valid strobes and returns the filter outputs through a result FIFO.
//
// state | meaning
// IDLE  | waiting for start
// WIND  | accepting TAPS coefficient words, replayed as wind beats
// LOAD  | accepting TAPS sample words, replayed as load beats
// RUN   | issuing run_len in_valid strobes, bounded by FIFO credits
// DRAIN | waiting for outstanding results and an empty FIFO
module fir_loader
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_TAPS,
  parameter int DW         = FIR_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_W      = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  fir_loader_if.slave      bus
);

  localparam int BW = $clog2(TAPS + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(TAPS - 1);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  fir_state_e       state_q, state_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic             err_q, err_d;
  logic             fir_wind_q, fir_wind_d;
  logic             fir_load_q, fir_load_d;
  logic             fir_in_valid_q, fir_in_valid_d;
  logic [DW-1:0]    fir_data_q, fir_data_d;

  logic             start_acc;
  logic             hs;
  logic             last_beat;
  logic             issue;
  logic             ret;
  logic             spurious;
  logic             drain_ok;
  logic [CW:0]      occ;

  logic             fifo_push;
  logic             fifo_pop;
  logic [DW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  res_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (fifo_push),
    .push_data (bus.fir_out),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_acc) state_d = WIND;
      WIND:    if (last_beat) state_d = LOAD;
      LOAD:    if (last_beat) state_d = (run_cnt_q == '0) ? DRAIN : RUN;
      RUN:     if (issue && run_cnt_q == RUN_W'(1)) state_d = DRAIN;
      DRAIN:   if (drain_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DRAIN) && drain_ok;
    bus.s_ready = (state_q == WIND) || (state_q == LOAD);
  end

  always_comb begin
    start_acc = start && (state_q == IDLE);
    hs        = bus.s_valid && bus.s_ready;
    last_beat = hs && (beat_cnt_q == '0);
    // Credits plus queued results must leave room for every strobe in flight.
    occ       = {1'b0, credit_q} + {1'b0, fifo_count};
    issue     = (state_q == RUN) && (run_cnt_q != '0) && (occ < DEPTH_C);
    ret       = bus.fir_out_valid && (credit_q != '0);
    spurious  = bus.fir_out_valid && (credit_q == '0);
    drain_ok  = (credit_q == '0) && fifo_empty;
    fifo_push = ret && !fifo_full;
    fifo_pop  = !fifo_empty && bus.m_ready;

    beat_cnt_d = beat_cnt_q;
    if (start_acc) begin
      beat_cnt_d = BEAT_LAST;
    end else if (hs) begin
      beat_cnt_d = (beat_cnt_q == '0) ? BEAT_LAST : beat_cnt_q - BW'(1);
    end

    run_cnt_d = run_cnt_q;
    if (start_acc) begin
      run_cnt_d = run_len;
    end else if (issue) begin
      run_cnt_d = run_cnt_q - RUN_W'(1);
    end

    credit_d = credit_q;
    if (issue && !ret) begin
      credit_d = credit_q + CW'(1);
    end else if (!issue && ret) begin
      credit_d = credit_q - CW'(1);
    end

    err_d = err_q;
    if (start_acc) err_d = 1'b0;
    if (spurious)  err_d = 1'b1;

    fir_wind_d     = hs && (state_q == WIND);
    fir_load_d     = hs && (state_q == LOAD);
    fir_in_valid_d = issue;
    fir_data_d     = hs ? bus.s_data : fir_data_q;
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      beat_cnt_q     <= '0;
      run_cnt_q      <= '0;
      credit_q       <= '0;
      err_q          <= 1'b0;
      fir_wind_q     <= 1'b0;
      fir_load_q     <= 1'b0;
      fir_in_valid_q <= 1'b0;
      fir_data_q     <= '0;
    end else begin
      beat_cnt_q     <= beat_cnt_d;
      run_cnt_q      <= run_cnt_d;
      credit_q       <= credit_d;
      err_q          <= err_d;
      fir_wind_q     <= fir_wind_d;
      fir_load_q     <= fir_load_d;
      fir_in_valid_q <= fir_in_valid_d;
      fir_data_q     <= fir_data_d;
    end
  end

  assign err              = err_q;
  assign bus.fir_wind     = fir_wind_q;
  assign bus.fir_load     = fir_load_q;
  assign bus.fir_in_valid = fir_in_valid_q;
  assign bus.fir_data     = fir_data_q;
  assign bus.m_valid      = !fifo_empty;
  assign bus.m_data       = fifo_head;

endmodule

// File: doc/fir_loader.md
Name: fir_loader

Overview:
- Host-side sequencer that drives the control/data interface of the `fir` filter block and collects its results.
- Takes TAPS coefficient words, then TAPS sample words, from an upstream valid/ready stream and replays them to `fir` as wind beats, then load beats.
- Then issues `run_len` in_valid strobes and returns each filter output on a downstream valid/ready stream.
- Sits between the chip's host/config path and `fir`, replacing hand-sequenced wind/load/in_valid stimulus.

Parameters:
- TAPS, 16, number of coefficient words and number of sample words per job.
- DW, 16, data word width on every data bus.
- FIFO_DEPTH, 4, result FIFO entries; also the credit limit on outstanding in_valid strobes (power of two, ≥2).
- RUN_W, 8, width of run_len.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstb  in  1  reset, asynchronous, active-high (the name is historical; polarity and synchronicity are fixed).
- start  in  1  one-cycle job request; honoured only in IDLE.
- run_len  in  RUN_W  number of in_valid strobes; sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the transition to IDLE after a job.
- err  out  1  sticky; set on an unexpected fir_out_valid; cleared on accepted start.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream ready.
- s_data  in  DW  upstream word.
- fir_wind  out  1  to fir.wind.
- fir_load  out  1  to fir.load.
- fir_in_valid  out  1  to fir.in_valid.
- fir_data  out  DW  to fir.data.
- fir_out_valid  in  1  from fir.out_valid.
- fir_out  in  DW  from fir.out.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_data  out  DW  result word.

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - FSM to IDLE.
  - All outputs 0, including s_ready, m_valid, fir_* and err.
  - Beat counter, run counter, credit counter and FIFO pointers to 0.
  - Reset mid-job aborts the job: no done pulse, FIFO contents discarded.
- FSM states: IDLE, WIND, LOAD, RUN, DRAIN.
  - IDLE→WIND on start; latch run_len; clear err.
  - WIND→LOAD after TAPS accepted words.
  - LOAD→RUN after TAPS accepted words.
  - RUN→DRAIN after run_len strobes issued.
  - DRAIN→IDLE when the credit counter is 0 and the FIFO is empty; done pulses in that cycle.
  - run_len=0: LOAD→DRAIN directly.
- s_ready is high only in WIND/LOAD.
- Each s_valid&&s_ready handshake registers fir_data=s_data and asserts fir_wind (WIND) or fir_load (LOAD) for exactly the next cycle.
  - A cycle with no handshake gives wind/load=0 on the next cycle; gaps are legal, since fir shifts only on asserted beats.
  - fir_data holds its last value when idle.
- All fir_* outputs are registered (no combinational path from s_* or m_ready).
- RUN: fir_in_valid is asserted (registered) in a cycle only if credits + FIFO occupancy < FIFO_DEPTH. This guarantees no result is ever dropped.
  - Credit counter: +1 per issued strobe, −1 per fir_out_valid, net 0 when both happen in the same cycle.
  - fir_data is held at the last loaded value during RUN.
- Each fir_out_valid with credits>0 pushes fir_out into the FIFO, including in the same cycle as a pop.
- fir_out_valid with credits=0 (any state):
  - Word is dropped and err is set.
  - Credits stay 0 (saturate, no wrap).
- FIFO output:
  - m_valid = not empty; m_data = head word.
  - Pop on m_valid&&m_ready.
  - Full and empty are distinguished with an extra pointer bit.
  - Ordering is strict FIFO.
- start while busy is ignored and does not touch err.
- Counters are wide enough for TAPS and 2^RUN_W−1 with no wrap.

Decomposition:
- Shared package `fir_pkg`:
  - `fir_state_e` enum (IDLE, WIND, LOAD, RUN, DRAIN).
  - Constants FIR_TAPS=16, FIR_DW=16.
- One sub-module `res_fifo`: synchronous FIFO, parameterised DW/FIFO_DEPTH, with push/pop/full/empty/count, same clk and rstb.
- The FSM, counters and credit logic live in `fir_loader`.

Test Plan:
- Basic job:
  - Stimulus: s_data stream 1..16 (coefs) then 1..16 (samples), s_valid held high, run_len=6, m_ready=1.
  - Response: exactly 16 fir_wind cycles carrying 1..16, then 16 fir_load cycles carrying 1..16, then 6 fir_in_valid cycles; done pulses once after all results drain.
- Gapped upstream:
  - Stimulus: s_valid toggles every other cycle.
  - Response: identical fir_wind/fir_load data sequence with idle gaps; wind/load never asserted without a new word.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, run_len=10, m_ready=0, bench fir model with 3-cycle latency.
  - Response: fir_in_valid stops after 4 strobes. With m_ready=1, all 10 results emerge in order with no loss, err=0.
- Zero run:
  - Stimulus: run_len=0.
  - Response: no fir_in_valid; done pulses 1 cycle after the last load beat.
- Spurious output:
  - Stimulus: fir_out_valid asserted in IDLE with fir_out=16'hBEEF.
  - Response: err=1, m_valid stays 0. Next start clears err.
- Reset mid-RUN:
  - Stimulus: assert rstb during the 3rd in_valid cycle.
  - Response: all outputs 0 immediately (async); busy=0; no done pulse; a new job runs correctly afterwards.
